wr_slave_arbiter: RTL and testbench

- Per-slave write-channel arbiter of the 2-master/2-slave AXI interconnect; one instance per slave.
- Sits directly upstream of the write-response return mux. Produces the `mas_sel` grant code that the mux decodes to route AWREADY/WREADY/BVALID/BRESP back to the owning master.
- Holds a grant for one complete write transaction (AW → W burst → B), then releases it.
- Tracks W beats against the captured AWLEN and flags mismatched WLAST.

---
 rtl/axi_ic_pkg.sv | 17 +
 rtl/wr_beat_cnt.sv | 60 ++++++
 rtl/wr_slave_arbiter.sv | 108 ++++++++++
 tb/tb_wr_slave_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared grant codes, write-arbiter state encoding and widths
package axi_ic_pkg;

  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_M1   = 2'b01;
  localparam logic [1:0] SEL_M2   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } wr_state_e;

endpackage

// File: rtl/wr_beat_cnt.sv
// rtl/wr_beat_cnt.sv - W beat counter, AWLEN capture and WLAST/length mismatch pulse
module wr_beat_cnt
  import axi_ic_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             aw_hs,
  input  logic             w_hs,
  input  logic             wlast,
  input  logic [LEN_W-1:0] awlen,
  output logic             aw_done,
  output logic             w_done,
  output logic             wlast_err,
  output logic [LEN_W-1:0] beat_cnt
);

  logic [LEN_W-1:0] len_q;
  logic             len_known;
  logic [LEN_W-1:0] len_eff;
  logic             err_beat;
  logic             err_late;

  // A beat sharing its edge with the AW handshake is judged against the incoming AWLEN.
  assign len_known = aw_done | aw_hs;
  assign len_eff   = aw_done ? len_q : awlen;
  assign err_beat  = w_hs & len_known &
                     (wlast ? (beat_cnt != len_eff) : (beat_cnt == len_eff));
  // Burst already closed by WLAST: beats seen so far must equal AWLEN+1.
  assign err_late  = aw_hs & w_done & ((beat_cnt - LEN_W'(1)) != awlen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      len_q     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wlast_err <= 1'b0;
    end else begin
      wlast_err <= err_beat | err_late;
      if (clr) begin
        beat_cnt <= '0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        if (aw_hs) begin
          len_q   <= awlen;
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
          if (wlast) w_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wr_slave_arbiter.sv
// rtl/wr_slave_arbiter.sv - per-slave write arbiter holding a grant from AW through B
// WR_ARB_RR_EN selects round-robin tie breaking; otherwise master 1 wins ties.
module wr_slave_arbiter
  import axi_ic_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             m1_req,
  input  logic             m2_req,
  input  logic [LEN_W-1:0] m1_AWLEN,
  input  logic [LEN_W-1:0] m2_AWLEN,
  input  logic             sl_AWVALID,
  input  logic             sl_AWREADY,
  input  logic             sl_WVALID,
  input  logic             sl_WREADY,
  input  logic             sl_WLAST,
  input  logic             sl_BVALID,
  input  logic             sl_BREADY,
  output logic [1:0]       mas_sel,
  output logic             busy,
  output logic             wlast_err
);

  wr_state_e        state, state_n;
  logic [1:0]       sel_n;
  logic             aw_hs, w_hs, b_hs;
  logic             aw_done, w_done;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] awlen_sel;
  logic [1:0]       winner;
`ifdef WR_ARB_RR_EN
  logic             rr_ptr, rr_n;
`endif

  assign aw_hs     = (state == ADDR) & sl_AWVALID & sl_AWREADY;
  assign w_hs      = ((state == ADDR) | (state == DATA)) & sl_WVALID & sl_WREADY;
  assign b_hs      = (state == RESP) & sl_BVALID & sl_BREADY;
  assign awlen_sel = (mas_sel == SEL_M2) ? m2_AWLEN : m1_AWLEN;

`ifdef WR_ARB_RR_EN
  assign winner = (m1_req & m2_req) ? (rr_ptr ? SEL_M2 : SEL_M1)
                                    : (m1_req ? SEL_M1 : SEL_M2);
`else
  assign winner = m1_req ? SEL_M1 : SEL_M2;
`endif

  wr_beat_cnt #(.LEN_W(LEN_W)) u_beat (
    .clk       (ACLK),
    .rst       (ARESET),
    .clr       (b_hs),
    .aw_hs     (aw_hs),
    .w_hs      (w_hs),
    .wlast     (sl_WLAST),
    .awlen     (awlen_sel),
    .aw_done   (aw_done),
    .w_done    (w_done),
    .wlast_err (wlast_err),
    .beat_cnt  (beat_cnt)
  );

  always_comb begin
    state_n = state;
    sel_n   = mas_sel;
`ifdef WR_ARB_RR_EN
    rr_n    = rr_ptr;
`endif
    case (state)
      IDLE: if (m1_req | m2_req) begin
        state_n = ADDR;
        sel_n   = winner;
      end
      ADDR: begin
        if ((aw_done | aw_hs) & (w_done | (w_hs & sl_WLAST))) state_n = RESP;
        else if (aw_done | aw_hs)                             state_n = DATA;
      end
      DATA: if (w_hs & sl_WLAST) state_n = RESP;
      RESP: if (b_hs) begin
        state_n = IDLE;
        sel_n   = SEL_NONE;
`ifdef WR_ARB_RR_EN
        rr_n    = (mas_sel == SEL_M1);
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      mas_sel <= SEL_NONE;
      busy    <= 1'b0;
`ifdef WR_ARB_RR_EN
      rr_ptr  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      mas_sel <= sel_n;
      busy    <= (state_n != IDLE);
`ifdef WR_ARB_RR_EN
      rr_ptr  <= rr_n;
`endif
    end
  end

endmodule

// File: tb/tb_wr_slave_arbiter.sv
// tb/tb_wr_slave_arbiter.sv - randomized write-transaction bench with grant/error reference model
module tb_wr_slave_arbiter;
  import axi_ic_pkg::*;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       m1_req = 1'b0, m2_req = 1'b0;
  logic [7:0] m1_AWLEN = '0, m2_AWLEN = '0;
  logic       sl_AWVALID = 1'b0, sl_AWREADY = 1'b0;
  logic       sl_WVALID = 1'b0, sl_WREADY = 1'b0, sl_WLAST = 1'b0;
  logic       sl_BVALID = 1'b0, sl_BREADY = 1'b0;
  logic [1:0] mas_sel;
  logic       busy, wlast_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int exp_rr = 0;

  wr_slave_arbiter #(.LEN_W(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m1_req(m1_req), .m2_req(m2_req),
    .m1_AWLEN(m1_AWLEN), .m2_AWLEN(m2_AWLEN),
    .sl_AWVALID(sl_AWVALID), .sl_AWREADY(sl_AWREADY),
    .sl_WVALID(sl_WVALID), .sl_WREADY(sl_WREADY), .sl_WLAST(sl_WLAST),
    .sl_BVALID(sl_BVALID), .sl_BREADY(sl_BREADY),
    .mas_sel(mas_sel), .busy(busy), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (wlast_err) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_sl();
    sl_AWVALID = 0; sl_AWREADY = 0;
    sl_WVALID = 0; sl_WREADY = 0; sl_WLAST = 0;
    sl_BVALID = 0; sl_BREADY = 0;
  endtask

  // pat: 1 = m1 only, 2 = m2 only, 3 = tie. order: 0 AW first, 1 AW with first beat, 2 AW after WLAST.
  task automatic run_txn(input int pat, input int awlen, input int nbeats, input int order);
    int exp_sel, exp_err, base;
    exp_sel = (pat == 2) ? 2 : 1;
`ifdef WR_ARB_RR_EN
    if (pat == 3) exp_sel = (exp_rr != 0) ? 2 : 1;
`endif
    check("idle_sel", 32'(mas_sel), 0);
    check("idle_busy", 32'(busy), 0);
    m1_req = (pat & 1) != 0;
    m2_req = (pat & 2) != 0;
    m1_AWLEN = (exp_sel == 1) ? 8'(awlen) : 8'($urandom);
    m2_AWLEN = (exp_sel == 2) ? 8'(awlen) : 8'($urandom);
    step();
    m1_req = 0; m2_req = 0;
    check("grant", 32'(mas_sel), 32'(exp_sel));
    check("busy", 32'(busy), 1);
    base = err_pulses;

    exp_err = 0;
    if (order == 2) exp_err = (nbeats - 1 != awlen) ? 1 : 0;
    else for (int i = 0; i < nbeats; i++)
      if (i == nbeats - 1) exp_err += (i != awlen) ? 1 : 0;
      else                 exp_err += (i == awlen) ? 1 : 0;

    if (order == 0) begin
      sl_AWVALID = 1;
      repeat ($urandom_range(0, 2)) step();
      sl_AWREADY = 1;
      step();
      clear_sl();
    end
    for (int i = 0; i < nbeats; i++) begin
      if (order == 0 && nbeats >= 2 && i == nbeats - 1) begin
        sl_BVALID = 1; sl_BREADY = 1;
        step();
        clear_sl();
        check("hold_in_data", 32'(mas_sel), 32'(exp_sel));
      end
      sl_WVALID = 1;
      repeat ($urandom_range(0, 1)) step();
      sl_WREADY = 1;
      sl_WLAST = (i == nbeats - 1);
      if (order == 1 && i == 0) begin sl_AWVALID = 1; sl_AWREADY = 1; end
      step();
      clear_sl();
    end
    if (order == 2) begin
      sl_AWVALID = 1; sl_AWREADY = 1;
      step();
      clear_sl();
    end
    check("beat_cnt", 32'(dut.u_beat.beat_cnt), 32'(nbeats % 256));
    check("sel_pre_b", 32'(mas_sel), 32'(exp_sel));
    sl_BVALID = 1;
    repeat ($urandom_range(0, 2)) step();
    sl_BREADY = 1;
    step();
    clear_sl();
    check("release_sel", 32'(mas_sel), 0);
    check("release_busy", 32'(busy), 0);
    step();
    check("wlast_err_cnt", 32'(err_pulses - base), 32'(exp_err));
    exp_rr = (exp_sel == 1) ? 1 : 0;
  endtask

  initial begin
    int awl;
    clear_sl();
    step(); step();
    check("rst_sel", 32'(mas_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(wlast_err), 0);
    ARESET = 0;
    step();

    run_txn(3, 1, 2, 0);
    run_txn(3, 1, 2, 0);
    run_txn(1, 3, 4, 0);
    run_txn(1, 0, 1, 1);
    run_txn(1, 2, 2, 0);
    run_txn(2, 1, 3, 0);
    run_txn(1, 1, 2, 2);

    // Asynchronous reset in the middle of a data phase.
    m1_req = 1;
    step();
    m1_req = 0;
    sl_AWVALID = 1; sl_AWREADY = 1;
    step();
    clear_sl();
    sl_WVALID = 1; sl_WREADY = 1;
    step();
    check("pre_rst_sel", 32'(mas_sel), 1);
    #2 ARESET = 1;
    #1;
    check("async_rst_sel", 32'(mas_sel), 0);
    check("async_rst_busy", 32'(busy), 0);
    clear_sl();
    step();
    ARESET = 0;
    exp_rr = 0;
    step();
    run_txn(2, 1, 2, 0);

    for (int t = 0; t < 40; t++) begin
      awl = $urandom_range(0, 4);
      run_txn($urandom_range(1, 3), awl,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : awl + 1,
              $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
